// File: rtl/sp_ram_multimode.sv
// sp_ram_multimode: single-port sync RAM, byte enables, MODE-selected
// write-port DO behaviour (0 no-change, 1 read-first, 2 write-first),
// post-reset zero-clear sequencer driving busy.
// Ports: CLK, RST_N (async, active-low), en, we, be, address, DI,
// DO (registered), dv (one-cycle valid strobe), busy (clear running).
// Option: define SP_RAM_OUTREG_EN for an extra DO/dv register stage.
module sp_ram_multimode #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 6,
  parameter  int MODE   = 0,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  output logic              dv,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("sp_ram_multimode: MODE must be 0, 1 or 2");
  end

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("sp_ram_multimode: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   do_q;
  logic                dv_q;
  logic                acc;

  // busy is its own flop so it falls on the edge of the last clear write
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      unique case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {ADDR_W{1'b1}}) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  assign acc    = en && !busy;
  assign rd_old = mem[address];

  // word as it will look after this write: new bytes where be is set
  always_comb begin
    merged = rd_old;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = DI[8*i +: 8];
    end
  end

  // storage has no reset; the clear sequence zeroes it instead
  always_ff @(posedge CLK) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[address][8*i +: 8] <= DI[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_q <= '0;
      dv_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (acc) begin
        unique case (1'b1)
          !we: begin
            do_q <= rd_old;
            dv_q <= 1'b1;
          end
          we && MODE == 1: begin
            do_q <= rd_old;
            dv_q <= 1'b1;
          end
          we && MODE == 2: begin
            do_q <= merged;
            dv_q <= 1'b1;
          end
          default: begin
            do_q <= do_q;
          end
        endcase
      end
    end
  end

`ifdef SP_RAM_OUTREG_EN
  logic [DATA_W-1:0] do_p;
  logic              dv_p;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_p <= '0;
      dv_p <= 1'b0;
    end else begin
      do_p <= do_q;
      dv_p <= dv_q;
    end
  end

  assign DO = do_p;
  assign dv = dv_p;
`else
  assign DO = do_q;
  assign dv = dv_q;
`endif

endmodule

// File: tb/tb_sp_ram_multimode.sv
// tb_sp_ram_multimode: directed bench for sp_ram_multimode,
// one instance per MODE (0,1,2) sharing the same stimulus.
module tb_sp_ram_multimode;

`ifdef SP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        en;
  logic        we;
  logic [1:0]  be;
  logic [5:0]  address;
  logic [15:0] DI;
  logic [15:0] do_w [3];
  logic        dv_w [3];
  logic        busy_w [3];

  int comps = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sp_ram_multimode #(
      .DATA_W(16),
      .ADDR_W(6),
      .MODE(g)
    ) u_dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .en(en),
      .we(we),
      .be(be),
      .address(address),
      .DI(DI),
      .DO(do_w[g]),
      .dv(dv_w[g]),
      .busy(busy_w[g])
    );
  end

  typedef struct {
    logic            w;
    logic [5:0]      a;
    logic [15:0]     d;
    logic [1:0]      b;
    logic [2:0][15:0] e;
    logic [2:0]      v;
  } step_t;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    en = 0; we = 0; be = 0; address = 0; DI = 0;
  endtask

  task automatic access(input logic w, input logic [5:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    en = 1; we = w; address = a; DI = d; be = b;
    cyc();
    idle_in();
    repeat (LAT - 1) cyc();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (n < 200) begin
      cyc();
      n++;
      if (busy_w[0] !== 1'b1) break;
    end
  endtask

  task automatic test_reset();
    int n;
    logic dv_seen;
    idle_in();
    RST_N = 0;
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      comps++;
      if (busy_w[k] !== 1'b1 || do_w[k] !== 16'h0 || dv_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d busy=%b DO=%h dv=%b want 1/0000/0",
                 k, busy_w[k], do_w[k], dv_w[k]);
      end
    end
    en = 1; we = 1; be = 2'b11; address = 6'd3; DI = 16'hFFFF;
    RST_N = 1;
    n = 0;
    dv_seen = 0;
    while (n < 200) begin
      cyc();
      n++;
      for (int k = 0; k < 3; k++) if (dv_w[k] !== 1'b0) dv_seen = 1;
      if (busy_w[0] !== 1'b1) break;
    end
    idle_in();
    comps++;
    if (n != 64) begin
      fails++;
      $display("FAIL busy_len got %0d cycles want 64", n);
    end
    comps++;
    if (dv_seen !== 1'b0) begin
      fails++;
      $display("FAIL dv_during_busy got 1 want 0");
    end
    for (int k = 0; k < 3; k++) begin
      comps++;
      if (busy_w[k] !== 1'b0 || do_w[k] !== 16'h0) begin
        fails++;
        $display("FAIL after_clear dut%0d busy=%b DO=%h want 0/0000",
                 k, busy_w[k], do_w[k]);
      end
    end
  endtask

  task automatic test_read_all_zero();
    for (int a = 0; a < 64; a++) begin
      access(1'b0, 6'(a), 16'h0, 2'b00);
      for (int k = 0; k < 3; k++) begin
        comps++;
        if (dv_w[k] !== 1'b1 || do_w[k] !== 16'h0) begin
          fails++;
          $display("FAIL zero_read dut%0d addr=%0d DO=%h dv=%b want 0000/1",
                   k, a, do_w[k], dv_w[k]);
        end
      end
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      comps++;
      if (dv_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL dv_strobe dut%0d dv=%b want 0", k, dv_w[k]);
      end
    end
  endtask

  task automatic test_modes();
    step_t s [10];
    s[0] = '{w:1, a:9, d:16'h1234, b:2'b11,
             e:{16'h1234, 16'h0000, 16'h0000}, v:3'b110};
    s[1] = '{w:0, a:9, d:16'h0000, b:2'b00,
             e:{16'h1234, 16'h1234, 16'h1234}, v:3'b111};
    s[2] = '{w:1, a:5, d:16'hA5A5, b:2'b11,
             e:{16'hA5A5, 16'h0000, 16'h1234}, v:3'b110};
    s[3] = '{w:0, a:5, d:16'h0000, b:2'b00,
             e:{16'hA5A5, 16'hA5A5, 16'hA5A5}, v:3'b111};
    s[4] = '{w:1, a:9, d:16'hABCD, b:2'b01,
             e:{16'h12CD, 16'h1234, 16'hA5A5}, v:3'b110};
    s[5] = '{w:0, a:9, d:16'h0000, b:2'b00,
             e:{16'h12CD, 16'h12CD, 16'h12CD}, v:3'b111};
    s[6] = '{w:1, a:9, d:16'hFFFF, b:2'b00,
             e:{16'h12CD, 16'h12CD, 16'h12CD}, v:3'b110};
    s[7] = '{w:0, a:9, d:16'h0000, b:2'b00,
             e:{16'h12CD, 16'h12CD, 16'h12CD}, v:3'b111};
    s[8] = '{w:1, a:5, d:16'h3C00, b:2'b10,
             e:{16'h3CA5, 16'hA5A5, 16'h12CD}, v:3'b110};
    s[9] = '{w:0, a:5, d:16'h0000, b:2'b00,
             e:{16'h3CA5, 16'h3CA5, 16'h3CA5}, v:3'b111};
    for (int i = 0; i < 10; i++) begin
      access(s[i].w, s[i].a, s[i].d, s[i].b);
      for (int k = 0; k < 3; k++) begin
        comps++;
        if (do_w[k] !== s[i].e[k] || dv_w[k] !== s[i].v[k]) begin
          fails++;
          $display("FAIL mode_step%0d dut%0d DO=%h dv=%b want %h/%b",
                   i, k, do_w[k], dv_w[k], s[i].e[k], s[i].v[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ra [4];
    logic [15:0] ex [4];
    int j;
    ra = '{6'd12, 6'd5, 6'd9, 6'd12};
    ex = '{16'hBEEF, 16'h3CA5, 16'h12CD, 16'hBEEF};
    en = 1; we = 1; be = 2'b11; address = 6'd12; DI = 16'hBEEF;
    cyc();
    for (int t = 0; t <= 3 + LAT; t++) begin
      if (t < 4) begin
        en = 1; we = 0; be = 0; DI = 0; address = ra[t];
      end else begin
        idle_in();
      end
      cyc();
      j = t - (LAT - 1);
      for (int k = 0; k < 3; k++) begin
        if (j >= 0 && j < 4) begin
          comps++;
          if (do_w[k] !== ex[j] || dv_w[k] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rd%0d dut%0d DO=%h dv=%b want %h/1",
                     j, k, do_w[k], dv_w[k], ex[j]);
          end
        end else if (j == 4) begin
          comps++;
          if (dv_w[k] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_tail dut%0d dv=%b want 0", k, dv_w[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic drop;
    RST_N = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      comps++;
      if (busy_w[k] !== 1'b1 || do_w[k] !== 16'h0 || dv_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL async_reset dut%0d busy=%b DO=%h dv=%b want 1/0000/0",
                 k, busy_w[k], do_w[k], dv_w[k]);
      end
    end
    cyc();
    RST_N = 1;
    drop = 0;
    repeat (30) begin
      cyc();
      if (busy_w[0] !== 1'b1) drop = 1;
    end
    comps++;
    if (drop !== 1'b0) begin
      fails++;
      $display("FAIL busy_pre_mid got drop=1 want 0");
    end
    RST_N = 0;
    cyc();
    comps++;
    if (busy_w[2] !== 1'b1) begin
      fails++;
      $display("FAIL busy_mid_reset got %b want 1", busy_w[2]);
    end
    RST_N = 1;
    wait_clear(n);
    comps++;
    if (n != 64) begin
      fails++;
      $display("FAIL busy_len_restart got %0d cycles want 64", n);
    end
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_read_all_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
